// File: rtl/load_store_unit.sv
// RV32I load/store unit: turns one MEM-stage request into aligned memory transfers,
// splitting misaligned accesses into byte transfers. LSU_MISALIGN_TRAP_EN traps them instead.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int TO_W           = 5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_xfer_size,
  input  logic [31:0] mem_read_data,
  input  logic        mem_rdy
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
`ifndef LSU_MISALIGN_TRAP_EN
  localparam logic [1:0] S_SPLIT  = 2'd2;
`endif
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            write_q, write_d;
  logic [2:0]      f3_q, f3_d;
  logic [31:0]     addr_q, addr_d, wdata_q, wdata_d, asm_q, asm_d;
  logic [1:0]      idx_q, idx_d;
  logic            err_q, err_d;
  logic [TO_W-1:0] to_q, to_d, to_inc;
  logic [2:0]      cur_n;
  logic [31:0]     size_mask, wshift;
  logic            req_illegal, req_mis, mem_busy, to_hit;

  function automatic logic [2:0] size_of(input logic [1:0] f);
    case (f)
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  assign req_illegal = (req_funct3[1:0] == 2'b11) || (req_funct3 == 3'b110) ||
                       (req_write && req_funct3[2]);
  assign req_mis     = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  assign cur_n       = size_of(f3_q[1:0]);
  assign size_mask   = (cur_n == 3'd1) ? 32'h0000_00ff :
                       (cur_n == 3'd2) ? 32'h0000_ffff : 32'hffff_ffff;
  assign wshift      = wdata_q >> {idx_q, 3'b000};
  assign to_inc      = to_q + 1'b1;
`ifndef LSU_MISALIGN_TRAP_EN
  assign mem_busy    = (state_q == S_ACCESS) || (state_q == S_SPLIT);
`else
  assign mem_busy    = (state_q == S_ACCESS);
`endif

  // Counts consecutive not-ready cycles of the current transfer; a zero limit never fires.
  always_comb begin
    to_d   = '0;
    to_hit = 1'b0;
    if (mem_busy && !mem_rdy) begin
      if ((TIMEOUT_CYCLES != 0) && (to_inc == TO_W'(TIMEOUT_CYCLES))) to_hit = 1'b1;
      else                                                            to_d   = to_inc;
    end
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    idx_d   = idx_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        write_d = req_write;
        f3_d    = req_funct3;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        asm_d   = '0;
        idx_d   = 2'd0;
        err_d   = 1'b0;
        if (req_illegal) begin
          err_d   = 1'b1;
          state_d = S_RESP;
        end else if (req_mis) begin
`ifdef LSU_MISALIGN_TRAP_EN
          err_d   = 1'b1;
          state_d = S_RESP;
`else
          state_d = S_SPLIT;
`endif
        end else begin
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: if (to_hit) begin
        err_d   = 1'b1;
        state_d = S_RESP;
      end else if (mem_rdy) begin
        asm_d   = mem_read_data & size_mask;
        state_d = S_RESP;
      end
`ifndef LSU_MISALIGN_TRAP_EN
      S_SPLIT: if (to_hit) begin
        err_d   = 1'b1;
        state_d = S_RESP;
      end else if (mem_rdy) begin
        for (int b = 0; b < 4; b++)
          if (idx_q == 2'(b)) asm_d[8*b +: 8] = mem_read_data[7:0];
        if ({1'b0, idx_q} == cur_n - 3'd1) state_d = S_RESP;
        else                               idx_d   = idx_q + 2'd1;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      write_q <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
      idx_q   <= 2'd0;
      err_q   <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP) && rst_n;
  assign resp_err   = resp_valid && err_q;

  always_comb begin
    resp_rdata = '0;
    if (resp_valid && !err_q && !write_q) begin
      case (f3_q)
        3'b000:  resp_rdata = {{24{asm_q[7]}}, asm_q[7:0]};
        3'b001:  resp_rdata = {{16{asm_q[15]}}, asm_q[15:0]};
        3'b100:  resp_rdata = {24'd0, asm_q[7:0]};
        3'b101:  resp_rdata = {16'd0, asm_q[15:0]};
        default: resp_rdata = asm_q;
      endcase
    end
  end

  // Gating by rst_n keeps a mid-operation reset from issuing a write in that cycle.
  always_comb begin
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_data   = '0;
    mem_xfer_size    = 3'd0;
    if (rst_n) begin
      if (state_q == S_ACCESS) begin
        mem_address      = addr_q;
        mem_xfer_size    = cur_n;
        mem_write_enable = write_q;
        mem_read_enable  = !write_q;
        mem_write_data   = wdata_q;
      end
`ifndef LSU_MISALIGN_TRAP_EN
      else if (state_q == S_SPLIT) begin
        mem_address      = addr_q + {30'd0, idx_q};
        mem_xfer_size    = 3'd1;
        mem_write_enable = write_q;
        mem_read_enable  = !write_q;
        mem_write_data   = {24'd0, wshift[7:0]};
      end
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-array memory, request-level reference model,
// per-cycle response checker and literal expectations from hand-worked cases.
module tb_load_store_unit;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_write_data, mem_read_data, mem_base;
  logic        mem_write_enable, mem_read_enable, mem_rdy;
  logic [2:0]  mem_xfer_size;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .TO_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_write_data(mem_write_data),
    .mem_xfer_size(mem_xfer_size), .mem_read_data(mem_read_data), .mem_rdy(mem_rdy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, wr_cnt = 0;
  logic mem_init = 1'b0;
  logic [7:0] mem [256];
  logic [7:0] ref_mem [256];

  // Expectations published by the driver, observations recorded by the checker.
  int exp_cyc = -1;
  logic exp_err = 1'b0, exp_nomem = 1'b0;
  logic [31:0] exp_rdata = '0;
  int seen = 0;
  logic got_err = 1'b0;
  logic [31:0] got_rdata = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory: drops low address bits per transfer size; read data is combinational.
  assign mem_base = mem_address & ~(32'(mem_xfer_size) - 32'd1);
  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 4; i++)
      if (i < int'(mem_xfer_size)) mem_read_data[8*i +: 8] = mem[8'(mem_base + 32'(i))];
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
      mem_init <= 1'b1;
    end else if (mem_write_enable && mem_rdy) begin
      wr_cnt <= wr_cnt + 1;
      for (int i = 0; i < 4; i++)
        if (i < int'(mem_xfer_size)) mem[8'(mem_base + 32'(i))] <= mem_write_data[8*i +: 8];
    end
  end

  always @(negedge clk) begin
    chk("resp_valid", 32'(resp_valid), 32'(cyc == exp_cyc));
    if (resp_valid) begin
      seen++;
      got_rdata = resp_rdata;
      got_err   = resp_err;
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("resp_err", 32'(resp_err), 32'(exp_err));
    end
    if (exp_nomem) chk("no_mem_access", 32'(mem_read_enable | mem_write_enable), 32'd0);
  end

  task automatic op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] wd, input int stall);
    int n, lat, exp_wr, w0, rem;
    logic legal, mis, err;
    logic [31:0] v;
    n = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : (f3[1:0] == 2'b10) ? 4 : 0;
    legal = (n != 0) && (f3 != 3'b110) && !(w && f3[2]);
    mis = legal && ((a % 32'(n)) != 32'd0);
    err = !legal;
`ifdef LSU_MISALIGN_TRAP_EN
    if (mis) err = 1'b1;
`endif
    lat = 1; exp_wr = 0; v = '0;
    if (!err) begin
      if (stall >= TO) begin
        err = 1'b1;
        lat = 1 + TO;
      end else begin
        lat = (mis ? n + 1 : 2) + stall;
        if (w) begin
          exp_wr = mis ? n : 1;
          for (int i = 0; i < n; i++) ref_mem[8'(a + 32'(i))] = wd[8*i +: 8];
        end else begin
          for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[8'(a + 32'(i))];
          if (f3 == 3'b000) v = {{24{v[7]}}, v[7:0]};
          if (f3 == 3'b001) v = {{16{v[15]}}, v[15:0]};
        end
      end
    end
    exp_err   = err;
    exp_rdata = (err || w) ? 32'd0 : v;
    exp_nomem = err && (stall == 0);
    w0 = wr_cnt;
    seen = 0;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    exp_cyc = cyc + lat;
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    rem = stall;
    mem_rdy = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0; req_wdata = '0;
    do begin
      @(negedge clk);
      if ((mem_read_enable || mem_write_enable) && rem > 0) begin
        mem_rdy = 1'b0;
        rem--;
      end else mem_rdy = 1'b1;
    end while (cyc <= exp_cyc);
    mem_rdy = 1'b1;
    exp_nomem = 1'b0;
    chk("resp_count", 32'(seen), 32'd1);
    chk("write_count", 32'(wr_cnt - w0), 32'(exp_wr));
    if (w && !err)
      for (int i = 0; i < n; i++) chk("mem_byte", 32'(mem[8'(a + 32'(i))]), 32'(ref_mem[8'(a + 32'(i))]));
  endtask

  task automatic lit(input string nm, input logic [31:0] rd, input logic e);
    chk({nm, "_rdata"}, got_rdata, rd);
    chk({nm, "_err"}, 32'(got_err), 32'(e));
  endtask

  initial begin
    int w0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; mem_rdy = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mem_en", 32'(mem_read_enable | mem_write_enable), 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    op(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0);
    op(1'b0, 3'b010, 32'h10, 32'h0, 0);  lit("lw_10",  32'hDEADBEEF, 1'b0);
    op(1'b0, 3'b000, 32'h13, 32'h0, 0);  lit("lb_13",  32'hFFFFFFDE, 1'b0);
    op(1'b0, 3'b100, 32'h13, 32'h0, 0);  lit("lbu_13", 32'h000000DE, 1'b0);
    op(1'b0, 3'b001, 32'h12, 32'h0, 0);  lit("lh_12",  32'hFFFFDEAD, 1'b0);
    op(1'b1, 3'b010, 32'h21, 32'h11223344, 0);
    op(1'b0, 3'b010, 32'h21, 32'h0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    lit("lw_21", 32'h0, 1'b1);
`else
    lit("lw_21", 32'h11223344, 1'b0);
`endif
    op(1'b1, 3'b001, 32'h31, 32'h00008001, 0);
    op(1'b0, 3'b001, 32'h31, 32'h0, 0);
    op(1'b0, 3'b101, 32'h23, 32'h0, 0);
`ifndef LSU_MISALIGN_TRAP_EN
    lit("lhu_23", 32'h00001122, 1'b0);
`endif
    op(1'b0, 3'b011, 32'h10, 32'h0, 0);  lit("ld_f3_011", 32'h0, 1'b1);
    op(1'b0, 3'b110, 32'h10, 32'h0, 0);
    op(1'b1, 3'b100, 32'h10, 32'h55, 0);
    op(1'b0, 3'b010, 32'h10, 32'h0, 3);  lit("lw_stall3", 32'hDEADBEEF, 1'b0);
    op(1'b0, 3'b010, 32'h10, 32'h0, 100); lit("lw_timeout", 32'h0, 1'b1);
    op(1'b0, 3'b010, 32'h10, 32'h0, 0);  lit("lw_after_to", 32'hDEADBEEF, 1'b0);
    op(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0, 0);
    op(1'b0, 3'b010, 32'h5, 32'h0, TO - 1);

`ifndef LSU_MISALIGN_TRAP_EN
    // Reset during the second byte of a split store: one byte lands, nothing more.
    w0 = wr_cnt;
    exp_cyc = -1;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h41; req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1 chk("rst_gates_write", 32'(mem_write_enable), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_split_ready", 32'(req_ready), 32'd1);
    chk("rst_split_writes", 32'(wr_cnt - w0), 32'd1);
    chk("rst_split_b0", 32'(mem[8'h41]), 32'h000000D4);
    chk("rst_split_b1", 32'(mem[8'h42]), 32'(ref_mem[8'h42]));
    ref_mem[8'h41] = 8'hD4;
    op(1'b0, 3'b000, 32'h41, 32'h0, 0);  lit("lb_41", 32'hFFFFFFD4, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the core's MEM stage and the byte-addressed data memory.
- Accepts one RV32I load/store per request and converts it into memory transfers (xfer_size 1/2/4).
- Memory aligns addresses by dropping low bits, so this block splits misaligned halfword/word accesses into sequential byte transfers.
- Returns sign- or zero-extended load data to the pipeline.

Parameters:
- TIMEOUT_CYCLES, 16: consecutive cycles mem_rdy may stay low in one transfer before abort. 0 disables the timeout.
- TO_W, 5: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101; stores use 000/001/010)
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores
- resp_err  out  1  valid with resp_valid: illegal funct3, timeout, or trapped misalign
- mem_address  out  32  to memory
- mem_write_enable  out  1  to memory
- mem_read_enable  out  1  to memory
- mem_write_data  out  32  to memory
- mem_xfer_size  out  3  1, 2 or 4
- mem_read_data  in  32  combinational read data from memory
- mem_rdy  in  1  memory ready

Behaviour:
- Interface: one clock, clk. Reset rst_n is synchronous and active-low.
- FSM states: IDLE, ACCESS, SPLIT, RESP. Registered state, latched request, byte index idx[1:0], assembly register asm[31:0], timeout counter.
- Reset values: state=IDLE, idx=0, asm=0, timeout count=0. All outputs 0 except req_ready=1.
- Memory-side outputs are combinational from state and are additionally gated by rst_n. A reset asserted mid-operation therefore issues no write that cycle and aborts with no response.
- IDLE:
  - On req_valid, latch the request.
  - Size n = 1 (funct3[1:0]=00), 2 (01) or 4 (10). funct3[1:0]=11, or funct3=110 or 111, or a store with funct3[2]=1, is illegal: go to RESP with err=1 and make no memory access.
  - Aligned means addr mod n == 0. Aligned goes to ACCESS; misaligned goes to SPLIT with idx=0.
- ACCESS:
  - Drive mem_address=addr, mem_xfer_size=n, and read_enable or write_enable per req_write.
  - mem_write_data is req_wdata unchanged.
  - When mem_rdy=1, capture mem_read_data[8n-1:0] into asm and go to RESP.
- SPLIT:
  - Drive mem_address=addr+idx (wraps modulo 2^32), xfer_size=1, mem_write_data={24'b0, wdata byte idx}.
  - When mem_rdy=1, write the read byte into asm byte idx.
  - If idx==n-1 go to RESP, else idx++.
- Timeout:
  - The counter runs while in ACCESS or SPLIT with mem_rdy=0 and clears on every mem_rdy=1.
  - Reaching TIMEOUT_CYCLES goes to RESP with err=1.
  - Bytes already stored by SPLIT are not rolled back.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - Loads: LB/LH sign-extend asm, LBU/LHU zero-extend, LW passes asm through.
  - Stores and errored requests: resp_rdata=0.
- Latency with mem_rdy held at 1:
  - Aligned access: accept at cycle 0, ACCESS at cycle 1, resp_valid at cycle 2.
  - Misaligned access: n SPLIT cycles, resp_valid at cycle n+1.
  - Illegal funct3: resp_valid at cycle 1.
- req_ready=0 outside IDLE; req_valid is ignored there. The earliest back-to-back accept is the cycle after RESP.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned request goes from IDLE directly to RESP with resp_err=1. No memory access is made, and the SPLIT state is not compiled.
- Undefined: misaligned requests are split as described above.

Test Plan:
- Reset, then SW addr=0x10 wdata=0xDEADBEEF, then LW 0x10 -> single xfer_size=4 write; load returns 0xDEADBEEF with resp_valid at cycle 2.
- LB from 0x13 (byte 0xDE) -> 0xFFFFFFDE. LBU from 0x13 -> 0x000000DE. LH from 0x12 -> 0xFFFFDEAD.
- SW addr=0x21 wdata=0x11223344 -> four byte writes to 0x21..0x24 (0x44, 0x33, 0x22, 0x11); resp at cycle 5. LW 0x21 -> 0x11223344. With LSU_MISALIGN_TRAP_EN: no write and resp_err=1 at cycle 1.
- funct3=011 load -> resp_err=1 at cycle 1, mem_read_enable and mem_write_enable never asserted.
- mem_rdy held 0 for TIMEOUT_CYCLES during LW -> resp_err=1, then IDLE. mem_rdy low 3 cycles then high -> normal result, resp_valid at cycle 5.
- rst_n low during the second SPLIT byte of a misaligned SW -> no further writes, no resp_valid, req_ready=1 the cycle after reset releases.
